write_back: RTL and testbench

- Writeback stage of the 5-stage MIPS pipeline; the producer end of the register-file write interface consumed by the decode stage (`reg_write_in`, `write_reg`, `write_data`).
- Accepts retiring instructions from the MEM stage. Selects the ALU result or load data (mem_to_reg) and drives one registered register-file write per instruction.
- Stalls the MEM stage while a variable-latency data-memory load is outstanding, with a timeout.

---
 rtl/write_back_if.sv | 28 ++
 rtl/write_back.sv | 122 ++++++++++++
 tb/tb_write_back.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_back_if.sv
// MEM -> WB handshake bundle: the retiring instruction plus the stage's ready.
// The MEM stage is the master; the writeback stage is the slave.
interface write_back_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [31:0] in_alu_result;
    logic [4:0]  in_write_reg;

    modport master (
        output in_valid,
        output in_reg_write,
        output in_mem_to_reg,
        output in_alu_result,
        output in_write_reg,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_reg_write,
        input  in_mem_to_reg,
        input  in_alu_result,
        input  in_write_reg,
        output in_ready
    );
endinterface

// File: rtl/write_back.sv
// Writeback stage: retires MEM-stage instructions as one registered register-file write,
// stalling on variable-latency loads with a bounded wait.
module write_back #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    write_back_if.slave        mem,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_rdata_valid,
    output logic               reg_write,
    output logic [4:0]         write_reg,
    output logic [31:0]        write_data,
    output logic [COUNT_W-1:0] retired_count,
    output logic               load_timeout,
    output logic               spurious_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {StIdle, StWaitLoad} state_t;

    state_t             state_q, state_d;
    logic [CntW-1:0]    wait_q, wait_d;
    logic [4:0]         cap_reg_q, cap_reg_d;
    logic               reg_write_q, reg_write_d;
    logic [4:0]         write_reg_q, write_reg_d;
    logic [31:0]        write_data_q, write_data_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               timeout_q, timeout_d;
    logic               spurious_q, spurious_d;

    logic accept;
    logic is_load;

    assign mem.in_ready = (state_q == StIdle);
    assign accept       = mem.in_valid & mem.in_ready;
    // Stores and branches never stall, whatever in_mem_to_reg says.
    assign is_load      = mem.in_reg_write & mem.in_mem_to_reg;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        cap_reg_d    = cap_reg_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        count_d      = count_q;
        timeout_d    = timeout_q;
        spurious_d   = spurious_q;

        unique case (state_q)
            StIdle: begin
                if (mem_rdata_valid) begin
                    spurious_d = 1'b1;
                end
                if (accept) begin
                    if (is_load) begin
                        cap_reg_d = mem.in_write_reg;
                        wait_d    = '0;
                        state_d   = StWaitLoad;
                    end else begin
                        reg_write_d  = mem.in_reg_write & (mem.in_write_reg != 5'd0);
                        write_reg_d  = mem.in_write_reg;
                        write_data_d = mem.in_alu_result;
                        count_d      = count_q + COUNT_W'(1);
                    end
                end
            end
            StWaitLoad: begin
                // Data on the final permitted cycle beats the timeout.
                if (mem_rdata_valid) begin
                    reg_write_d  = (cap_reg_q != 5'd0);
                    write_reg_d  = cap_reg_q;
                    write_data_d = mem_rdata;
                    count_d      = count_q + COUNT_W'(1);
                    state_d      = StIdle;
                end else if (wait_q == CntW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    wait_d    = '0;
                    state_d   = StIdle;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            cap_reg_q    <= 5'd0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= 32'd0;
            count_q      <= '0;
            timeout_q    <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            cap_reg_q    <= cap_reg_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            count_q      <= count_d;
            timeout_q    <= timeout_d;
            spurious_q   <= spurious_d;
        end
    end

    assign reg_write      = reg_write_q;
    assign write_reg      = write_reg_q;
    assign write_data     = write_data_q;
    assign retired_count  = count_q;
    assign load_timeout   = timeout_q;
    assign spurious_rdata = spurious_q;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: a scoreboard of expected register-file writes,
// pushed as instructions are presented and popped on the cycle the write appears.
module tb_write_back;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] retired_count;
    logic        load_timeout;
    logic        spurious_rdata;

    write_back_if mem_if ();

    write_back #(
        .TIMEOUT(16),
        .COUNT_W(32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem            (mem_if),
        .mem_rdata      (mem_rdata),
        .mem_rdata_valid(mem_rdata_valid),
        .reg_write      (reg_write),
        .write_reg      (write_reg),
        .write_data     (write_data),
        .retired_count  (retired_count),
        .load_timeout   (load_timeout),
        .spurious_rdata (spurious_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         got;
    wr_t         exp;
    logic [31:0] exp_count;
    int          errors = 0;
    int          checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_if.in_valid      = 1'b0;
        mem_if.in_reg_write  = 1'b0;
        mem_if.in_mem_to_reg = 1'b0;
        mem_if.in_alu_result = 32'd0;
        mem_if.in_write_reg  = 5'd0;
        mem_rdata_valid      = 1'b0;
        mem_rdata            = 32'd0;
    endtask

    task automatic present(input logic rw, input logic m2r, input logic [4:0] rd,
                           input logic [31:0] alu);
        mem_if.in_valid      = 1'b1;
        mem_if.in_reg_write  = rw;
        mem_if.in_mem_to_reg = m2r;
        mem_if.in_write_reg  = rd;
        mem_if.in_alu_result = alu;
    endtask

    task automatic test_reset();
        checks++;
        if ({reg_write, write_reg, write_data} !== 38'd0) begin
            errors++;
            $display("FAIL reset_write got we=%0b rd=%0d data=%h required 0/0/0",
                     reg_write, write_reg, write_data);
        end
        checks++;
        if (retired_count !== 32'd0 || load_timeout !== 1'b0 || spurious_rdata !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got count=%0d to=%0b sp=%0b required 0/0/0",
                     retired_count, load_timeout, spurious_rdata);
        end
        checks++;
        if (mem_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %0b required 1", mem_if.in_ready);
        end
    endtask

    task automatic test_alu();
        present(1'b1, 1'b0, 5'd8, 32'h0000_1234);
        sb.push_back('{we: 1'b1, rd: 5'd8, data: 32'h0000_1234});
        exp_count++;
        tick();
        drive_idle();
        exp = sb.pop_front();
        got = '{we: reg_write, rd: write_reg, data: write_data};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL alu_write got %h required %h", got, exp);
        end
        checks++;
        if (retired_count !== exp_count) begin
            errors++;
            $display("FAIL alu_count got %0d required %0d", retired_count, exp_count);
        end
        tick();
        checks++;
        if (reg_write !== 1'b0) begin
            errors++;
            $display("FAIL alu_pulse got reg_write=%0b required 0", reg_write);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            present(1'b1, 1'b0, 5'(i), 32'(10 * i));
            sb.push_back('{we: 1'b1, rd: 5'(i), data: 32'(10 * i)});
            exp_count++;
            tick();
            exp = sb.pop_front();
            got = '{we: reg_write, rd: write_reg, data: write_data};
            checks++;
            if (got !== exp || mem_if.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_write[%0d] got %h ready=%0b required %h ready=1",
                         i, got, mem_if.in_ready, exp);
            end
        end
        drive_idle();
        checks++;
        if (retired_count !== exp_count) begin
            errors++;
            $display("FAIL b2b_count got %0d required %0d", retired_count, exp_count);
        end
        tick();
    endtask

    task automatic test_load();
        present(1'b1, 1'b1, 5'd9, 32'h0000_0400);
        exp_count++;
        tick();
        drive_idle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem_if.in_ready !== 1'b0 || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL load_stall[%0d] got ready=%0b we=%0b required 0/0",
                         k, mem_if.in_ready, reg_write);
            end
            if (k == 2) begin
                mem_rdata       = 32'hDEAD_BEEF;
                mem_rdata_valid = 1'b1;
                sb.push_back('{we: 1'b1, rd: 5'd9, data: 32'hDEAD_BEEF});
            end
            tick();
        end
        drive_idle();
        exp = sb.pop_front();
        got = '{we: reg_write, rd: write_reg, data: write_data};
        checks++;
        if (got !== exp || retired_count !== exp_count) begin
            errors++;
            $display("FAIL load_write got %h count=%0d required %h count=%0d",
                     got, retired_count, exp, exp_count);
        end
        checks++;
        if (mem_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_release got ready=%0b required 1", mem_if.in_ready);
        end
        present(1'b1, 1'b0, 5'd5, 32'h0000_0055);
        sb.push_back('{we: 1'b1, rd: 5'd5, data: 32'h0000_0055});
        exp_count++;
        tick();
        drive_idle();
        exp = sb.pop_front();
        got = '{we: reg_write, rd: write_reg, data: write_data};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL load_follow got %h required %h", got, exp);
        end
        tick();
    endtask

    task automatic test_timeout();
        present(1'b1, 1'b1, 5'd10, 32'h0000_0800);
        tick();
        drive_idle();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (mem_if.in_ready !== 1'b0 || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait[%0d] got ready=%0b we=%0b required 0/0",
                         k, mem_if.in_ready, reg_write);
            end
            tick();
        end
        checks++;
        if (mem_if.in_ready !== 1'b1 || load_timeout !== 1'b1 || reg_write !== 1'b0 ||
            retired_count !== exp_count) begin
            errors++;
            $display("FAIL timeout_end got ready=%0b to=%0b we=%0b count=%0d required 1/1/0/%0d",
                     mem_if.in_ready, load_timeout, reg_write, retired_count, exp_count);
        end
        // Clear the sticky flag so the last-cycle case can show it staying low.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 32'd0;
        present(1'b1, 1'b1, 5'd11, 32'h0000_0c00);
        exp_count++;
        tick();
        drive_idle();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (mem_if.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL lastcycle_wait[%0d] got ready=%0b required 0", k, mem_if.in_ready);
            end
            if (k == 15) begin
                mem_rdata       = 32'hA5A5_0011;
                mem_rdata_valid = 1'b1;
                sb.push_back('{we: 1'b1, rd: 5'd11, data: 32'hA5A5_0011});
            end
            tick();
        end
        drive_idle();
        exp = sb.pop_front();
        got = '{we: reg_write, rd: write_reg, data: write_data};
        checks++;
        if (got !== exp || load_timeout !== 1'b0 || retired_count !== exp_count) begin
            errors++;
            $display("FAIL lastcycle_write got %h to=%0b count=%0d required %h to=0 count=%0d",
                     got, load_timeout, retired_count, exp, exp_count);
        end
        tick();
    endtask

    task automatic test_zero_and_store();
        present(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF);
        sb.push_back('{we: 1'b0, rd: 5'd0, data: 32'hFFFF_FFFF});
        exp_count++;
        tick();
        exp = sb.pop_front();
        got = '{we: reg_write, rd: write_reg, data: write_data};
        checks++;
        if (got !== exp || retired_count !== exp_count) begin
            errors++;
            $display("FAIL zero_reg got %h count=%0d required %h count=%0d",
                     got, retired_count, exp, exp_count);
        end
        present(1'b0, 1'b1, 5'd7, 32'h0000_0100);
        sb.push_back('{we: 1'b0, rd: 5'd7, data: 32'h0000_0100});
        exp_count++;
        tick();
        drive_idle();
        exp = sb.pop_front();
        got = '{we: reg_write, rd: write_reg, data: write_data};
        checks++;
        if (got !== exp || retired_count !== exp_count || mem_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL store got %h count=%0d ready=%0b required %h count=%0d ready=1",
                     got, retired_count, mem_if.in_ready, exp, exp_count);
        end
        tick();
    endtask

    task automatic test_spurious();
        mem_rdata       = 32'h1357_9BDF;
        mem_rdata_valid = 1'b1;
        tick();
        drive_idle();
        checks++;
        if (spurious_rdata !== 1'b1 || reg_write !== 1'b0 || retired_count !== exp_count) begin
            errors++;
            $display("FAIL spurious got sp=%0b we=%0b count=%0d required 1/0/%0d",
                     spurious_rdata, reg_write, retired_count, exp_count);
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        present(1'b1, 1'b1, 5'd12, 32'h0000_1000);
        tick();
        drive_idle();
        tick();
        reset           = 1'b1;
        mem_rdata       = 32'h0000_0077;
        mem_rdata_valid = 1'b1;
        tick();
        drive_idle();
        reset     = 1'b0;
        exp_count = 32'd0;
        checks++;
        if ({reg_write, write_reg, write_data} !== 38'd0 || retired_count !== exp_count) begin
            errors++;
            $display("FAIL midload_reset got we=%0b rd=%0d data=%h count=%0d required zeros",
                     reg_write, write_reg, write_data, retired_count);
        end
        checks++;
        if (load_timeout !== 1'b0 || spurious_rdata !== 1'b0 || mem_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midload_flags got to=%0b sp=%0b ready=%0b required 0/0/1",
                     load_timeout, spurious_rdata, mem_if.in_ready);
        end
        tick();
        checks++;
        if (reg_write !== 1'b0 || mem_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midload_after got we=%0b ready=%0b required 0/1",
                     reg_write, mem_if.in_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_count = 32'd0;
        reset     = 1'b1;
        drive_idle();
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_timeout();
        test_zero_and_store();
        test_spurious();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
